dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the five-stage pipelined core; it is the target end of the core's load/store interface.
- Accepts one load/store request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, performs a byte-enabled word access on an internal array, and returns a response over a second valid/ready handshake.
- Flags misaligned and out-of-range accesses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, at least 4).
- WAIT_CYCLES, 1, extra cycles between request accept and response valid (0..15).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables, bit i enables byte lane i (bits 8i+7:8i).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes response.
- rsp_rdata  out  32  load data (0 for stores and errors).
- rsp_err  out  1  access was misaligned or out of range.

Behaviour:
- Reset values:
  - req_ready=0 while reset is asserted, 1 in the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, wait counter=0.
  - Array contents are NOT reset. Simulation initialises them to 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: capture we/addr/wdata/be and load the counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - req_ready=0. The counter decrements each cycle.
  - When the counter reaches 1, go to RESP on the next edge.
- Access at the edge entering RESP:
  - Error check: err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH_WORDS).
  - Store without error: write each enabled lane of word addr[31:2]. Disabled lanes are unchanged.
  - Load without error: rsp_rdata = full word. req_be is ignored for loads; the core extracts bytes and halfwords.
  - Error: no write, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err stable until rsp_valid&&rsp_ready.
  - On the handshake edge: go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
  - No new request is accepted in the same cycle as the response handshake.
- Latency:
  - rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accepting edge.
  - Minimum request-to-request spacing is WAIT_CYCLES+2 cycles with rsp_ready held high.
- Backpressure: if rsp_ready stays low, the responder holds in RESP indefinitely and req_ready stays 0.
- req_valid while not ready is ignored. Request fields need only be stable in the accept cycle.
- Reset asserted mid-transaction:
  - In-flight access aborted, all outputs go to reset values immediately.
  - A store not yet performed (still in WAIT) is never performed.
- Address is word-indexed with addr[31:2]. No wrap-around: indices at or above DEPTH_WORDS are errors, not aliases.

Optional Feature:
- Macro DMEM_RSP_PERF_EN.
- Defined:
  - Adds 32-bit counters rd_count, wr_count and err_count, incremented on the edge entering RESP, plus stall_count, incremented each cycle in RESP with rsp_ready=0.
  - All counters reset to 0 and wrap at 2^32.
  - Exposed as output ports perf_rd, perf_wr, perf_err and perf_stall, 32 bits each.
- Undefined: counters and ports absent. Functional behaviour is identical.

Decomposition:
- Shared package dmem_pkg:
  - FSM state enum dmem_state_t {IDLE, WAIT, RESP}.
  - Constant WORD_BYTES=4.
  - NOP_RDATA=32'd0.
- One sub-module dmem_array: single-port, byte-enabled synchronous-write word array with parameter DEPTH_WORDS and combinational read by index.
- FSM, counter and error check stay in dmem_responder.

Test Plan:
- Aligned store, then load, WAIT_CYCLES=1:
  - Stimulus: store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load addr 0x10.
  - Response: load returns rsp_rdata=0xDEADBEEF, rsp_err=0.
  - Timing: rsp_valid rises 2 cycles after each accept.
- Partial store:
  - Stimulus: preload 0x11223344 at 0x20, then store wdata 0xAABBCCDD, be 4'b0101.
  - Response: load of 0x20 returns 0x11BB33DD.
- Errors:
  - Stimulus: load addr 0x22 (misaligned), then store to addr 4*DEPTH_WORDS.
  - Response: both give rsp_err=1 and rsp_rdata=0; a later load of word 0 is unchanged.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - Response: rsp_valid and rsp_rdata are stable and req_ready=0 throughout. The handshake then completes and req_ready=1 the next cycle.
- WAIT_CYCLES=0 back-to-back:
  - Stimulus: req_valid and rsp_ready held high.
  - Response: rsp_valid the cycle after accept; accepts occur every 2 cycles.
- Reset mid-operation:
  - Stimulus: with WAIT_CYCLES=3, assert reset one cycle after accepting a store of 0xCAFEF00D to 0x40.
  - Response: outputs go to reset values asynchronously, and a later load of 0x40 returns the prior value 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, the word width in bytes and the response data for stores and errors.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] NOP_RDATA  = 32'd0;

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word array: single port, synchronous write, combinational read by index.
// Latency: write lands on the clock edge, read is same-cycle; no backpressure.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    input  logic [WORD_BYTES-1:0]          be,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage; perf counters exist only with DMEM_RSP_PERF_EN defined.
// Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept cycle; one request in flight.
// Backpressure: holds the response while rsp_ready is low, req_ready stays 0 until the handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_RSP_PERF_EN
    ,
    output logic [31:0] perf_rd,
    output logic [31:0] perf_wr,
    output logic [31:0] perf_err,
    output logic [31:0] perf_stall
`endif
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dmem_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        live;

    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        enter_resp;
    logic        rsp_done;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_err;
    logic        arr_we;
    logic [31:0] arr_rdata;

    // live keeps req_ready low while reset is held and rises on the first edge after release.
    assign req_ready = (state == IDLE) && live;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign rsp_done  = rsp_valid && rsp_ready;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // With no wait states the access happens on the accepting edge, so take the ports directly.
    assign acc_we    = (state == IDLE) ? req_we    : cap_we;
    assign acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign acc_be    = (state == IDLE) ? req_be    : cap_be;

    assign acc_err = (acc_addr[1:0] != 2'b00) ||
                     (32'(acc_addr[31:2]) >= 32'(DEPTH_WORDS));
    assign arr_we  = enter_resp && acc_we && !acc_err;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
        end else if (accept) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= NOP_RDATA;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= (acc_we || acc_err) ? NOP_RDATA : arr_rdata;
            err_q   <= acc_err;
        end else if (rsp_done) begin
            rdata_q <= NOP_RDATA;
            err_q   <= 1'b0;
        end
    end

`ifdef DMEM_RSP_PERF_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic [31:0] err_count;
    logic [31:0] stall_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count    <= 32'd0;
            wr_count    <= 32'd0;
            err_count   <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (enter_resp && !acc_we) begin
                rd_count <= rd_count + 32'd1;
            end
            if (enter_resp && acc_we) begin
                wr_count <= wr_count + 32'd1;
            end
            if (enter_resp && acc_err) begin
                err_count <= err_count + 32'd1;
            end
            if (rsp_valid && !rsp_ready) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

    assign perf_rd    = rd_count;
    assign perf_wr    = wr_count;
    assign perf_err   = err_count;
    assign perf_stall = stall_count;
`endif

endmodule
